// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM download packer: bank map defaults,
// FIFO entry field widths and the output FSM encoding.
package jtframe_dwnld_pkg;

  localparam int IOCTL_AW = 25;
  localparam int BYTE_W   = 8;
  localparam int DATA_W   = 16;
  localparam int BA_W     = 2;
  localparam int MASK_W   = 2;

  localparam logic [IOCTL_AW-1:0] BA1_START_DEF = 25'h080000;
  localparam logic [IOCTL_AW-1:0] BA2_START_DEF = 25'h100000;
  localparam logic [IOCTL_AW-1:0] BA3_START_DEF = 25'h180000;

  // Byte enables are active-low; bit1 is the upper byte.
  localparam logic [MASK_W-1:0] MASK_LO   = 2'b10;
  localparam logic [MASK_W-1:0] MASK_HI   = 2'b01;
  localparam logic [MASK_W-1:0] MASK_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [BA_W-1:0] bank_sel(
    input logic [IOCTL_AW-1:0] addr,
    input logic [IOCTL_AW-1:0] ba1,
    input logic [IOCTL_AW-1:0] ba2,
    input logic [IOCTL_AW-1:0] ba3
  );
    if (addr < ba1)      return 2'd0;
    else if (addr < ba2) return 2'd1;
    else if (addr < ba3) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO holding packed SDRAM write requests.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module jtframe_dwnld_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Turns the byte-wide ioctl download stream into banked 16-bit SDRAM writes,
// buffering them in a small FIFO so prog_rdy latency does not stall the loader.
module jtframe_dwnld_pack
  import jtframe_dwnld_pkg::*;
#(
  parameter int                  SDRAMW    = 23,
  parameter logic [IOCTL_AW-1:0] BA1_START = BA1_START_DEF,
  parameter logic [IOCTL_AW-1:0] BA2_START = BA2_START_DEF,
  parameter logic [IOCTL_AW-1:0] BA3_START = BA3_START_DEF,
  parameter int                  FIFO_AW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [BYTE_W-1:0]   ioctl_dout,
  input  logic                ioctl_wr,
  output logic [SDRAMW-1:0]   prog_addr,
  output logic [DATA_W-1:0]   prog_data,
  output logic [MASK_W-1:0]   prog_mask,
  output logic [BA_W-1:0]     prog_ba,
  output logic                prog_we,
  input  logic                prog_rdy,
  output logic                dwnld_busy,
  output logic                overflow
);

  localparam int ENTRY_W = BA_W + SDRAMW + DATA_W + MASK_W;

  logic [BA_W-1:0]     ba_c;
  logic [IOCTL_AW-1:0] start_c, offset_c;
  logic [MASK_W-1:0]   mask_c;
  logic                unused_offset;

  logic                pipe_valid_q;
  logic [ENTRY_W-1:0]  pipe_entry_q;
  logic                dl_q;
  state_e              state_q;

  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;

  always_comb begin
    ba_c = bank_sel(ioctl_addr, BA1_START, BA2_START, BA3_START);
    case (ba_c)
      2'd0:    start_c = '0;
      2'd1:    start_c = BA1_START;
      2'd2:    start_c = BA2_START;
      default: start_c = BA3_START;
    endcase
    offset_c = ioctl_addr - start_c;
    mask_c   = offset_c[0] ? MASK_HI : MASK_LO;
  end

  // Offset bits above the word address are dropped on purpose: no wrap detection.
  assign unused_offset = ^offset_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_q <= 1'b0;
      pipe_entry_q <= '0;
    end else begin
      pipe_valid_q <= ioctl_wr;
      if (ioctl_wr)
        pipe_entry_q <= {ba_c, offset_c[SDRAMW:1], {2{ioctl_dout}}, mask_c};
    end
  end

  assign fifo_pop  = (state_q == ST_WRITE) & prog_rdy;
  assign fifo_push = pipe_valid_q & (~fifo_full | fifo_pop);

  jtframe_dwnld_fifo #(
    .W  (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (pipe_entry_q),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A drop in the same cycle as the clearing edge still reports overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      overflow   <= 1'b0;
      dwnld_busy <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (pipe_valid_q && !fifo_push)  overflow <= 1'b1;
      else if (downloading && !dl_q)   overflow <= 1'b0;
      dwnld_busy <= downloading | ~fifo_empty | (state_q != ST_IDLE) | pipe_valid_q;
    end
  end

  // Request outputs are latched from the FIFO head on IDLE->WRITE and held
  // until prog_rdy, so they stay stable for the whole write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
      prog_ba   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_WRITE;
            prog_we   <= 1'b1;
            prog_ba   <= fifo_head[ENTRY_W-1 -: BA_W];
            prog_addr <= fifo_head[DATA_W+MASK_W +: SDRAMW];
            prog_data <= fifo_head[MASK_W +: DATA_W];
            prog_mask <= fifo_head[MASK_W-1:0];
          end
        end
        ST_WRITE: begin
          if (prog_rdy) begin
            state_q <= ST_GAP;
            prog_we <= 1'b0;
          end
        end
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Randomized self-checking bench for jtframe_dwnld_pack with a bank-map model
// and an expected-write queue.
module tb_jtframe_dwnld_pack;

  localparam int SDRAMW = 23;
  localparam int EW     = 2 + SDRAMW + 16 + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              downloading;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic [1:0]        prog_ba;
  logic              prog_we;
  logic              prog_rdy;
  logic              dwnld_busy;
  logic              overflow;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [24:0] bnd [9] = '{25'h0000000, 25'h007FFFF, 25'h0080000, 25'h0080001,
                           25'h00FFFFF, 25'h0100000, 25'h017FFFF, 25'h0180000,
                           25'h1FFFFFF};

  jtframe_dwnld_pack #(.SDRAMW(SDRAMW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] start, off;
    logic [1:0]  ba;
    if (a < 25'h080000)      begin ba = 2'd0; start = 25'h000000; end
    else if (a < 25'h100000) begin ba = 2'd1; start = 25'h080000; end
    else if (a < 25'h180000) begin ba = 2'd2; start = 25'h100000; end
    else                     begin ba = 2'd3; start = 25'h180000; end
    off = a - start;
    return {ba, off[SDRAMW:1], d, d, (off[0] ? 2'b01 : 2'b10)};
  endfunction

  function automatic logic [24:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return bnd[$urandom_range(0, 8)];
    return 25'($urandom_range(0, 32'h1FFFFFF));
  endfunction

  function automatic logic [EW-1:0] observed();
    return {prog_ba, prog_addr, prog_data, prog_mask};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  // Waits (bounded) for a write request, holds prog_rdy off for 'delay' cycles
  // while tracking stability, then acknowledges it.
  task automatic serve_one(input int delay, output logic [EW-1:0] got,
                           output bit timeout, output bit stable, output logic we_after);
    int n = 0;
    timeout = 1'b0;
    stable  = 1'b1;
    while (prog_we !== 1'b1 && n < 50) begin step(); n++; end
    if (prog_we !== 1'b1) begin
      timeout  = 1'b1;
      got      = 'x;
      we_after = 1'bx;
      return;
    end
    got = observed();
    repeat (delay) begin
      step();
      if (observed() !== got || prog_we !== 1'b1) stable = 1'b0;
    end
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    we_after = prog_we;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) step();
    total++; if (prog_we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%b exp=0", prog_we); end
    total++; if (prog_addr !== '0)    begin bad++; $display("FAIL reset_addr got=%h exp=0", prog_addr); end
    total++; if (prog_data !== '0)    begin bad++; $display("FAIL reset_data got=%h exp=0", prog_data); end
    total++; if (prog_mask !== 2'b11) begin bad++; $display("FAIL reset_mask got=%b exp=11", prog_mask); end
    total++; if (prog_ba !== 2'b00)   begin bad++; $display("FAIL reset_ba got=%b exp=00", prog_ba); end
    total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", dwnld_busy); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [EW-1:0] exp;
    downloading = 1'b1;
    step();
    exp = model(25'h000003, 8'hA5);
    send_byte(25'h000003, 8'hA5);
    total++; if (prog_we !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%b exp=0", prog_we); end
    step();
    total++; if (prog_we !== 1'b0) begin bad++; $display("FAIL single_lat2 got=%b exp=0", prog_we); end
    step();
    total++; if (prog_we !== 1'b1) begin bad++; $display("FAIL single_lat3 got=%b exp=1", prog_we); end
    total++; if (observed() !== exp) begin bad++; $display("FAIL single_fields got=%h exp=%h", observed(), exp); end
    total++; if (observed() !== {2'd0, 23'd1, 16'hA5A5, 2'b01})
      begin bad++; $display("FAIL single_const got=%h exp=%h", observed(), {2'd0, 23'd1, 16'hA5A5, 2'b01}); end
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    total++; if (prog_we !== 1'b0) begin bad++; $display("FAIL single_ack got=%b exp=0", prog_we); end
    repeat (2) step();
  endtask

  task automatic test_banks();
    logic [EW-1:0] got;
    bit to, st;
    logic wa;
    exp_q.push_back({2'd1, 23'd0, 16'h3C3C, 2'b10});
    exp_q.push_back({2'd3, 23'd0, 16'hC3C3, 2'b01});
    send_byte(25'h080000, 8'h3C);
    send_byte(25'h180001, 8'hC3);
    for (int i = 0; i < 2; i++) begin
      logic [EW-1:0] exp = exp_q.pop_front();
      serve_one(i, got, to, st, wa);
      total++;
      if (to || !st || wa !== 1'b0 || got !== exp) begin
        bad++;
        $display("FAIL banks_write%0d got=%h exp=%h timeout=%0b stable=%0b we_after=%b", i, got, exp, to, st, wa);
      end
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] got;
    bit to, st;
    logic wa;
    for (int it = 0; it < 8; it++) begin
      int k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        logic [24:0] a = rand_addr();
        logic [7:0]  d = 8'($urandom);
        exp_q.push_back(model(a, d));
        send_byte(a, d);
      end
      for (int j = 0; j < k; j++) begin
        logic [EW-1:0] exp = exp_q.pop_front();
        serve_one($urandom_range(0, 3), got, to, st, wa);
        total++;
        if (to || !st || wa !== 1'b0 || got !== exp) begin
          bad++;
          $display("FAIL rand_write it=%0d j=%0d got=%h exp=%h timeout=%0b stable=%0b we_after=%b", it, j, got, exp, to, st, wa);
        end
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_overflow();
    int occupancy = 0;
    for (int i = 0; i < 6; i++) begin
      logic [24:0] a = rand_addr();
      logic [7:0]  d = 8'($urandom);
      if (occupancy < 4) begin exp_q.push_back(model(a, d)); occupancy++; end
      send_byte(a, d);
      if (i == 4) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    repeat (3) step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (prog_we !== 1'b1 || observed() !== exp_q[0])
      begin bad++; $display("FAIL ovf_head we=%b got=%h exp=%h", prog_we, observed(), exp_q[0]); end
  endtask

  task automatic test_drain();
    logic [EW-1:0] got;
    bit to, st;
    logic wa;
    downloading = 1'b0;
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_ovf_hold got=%b exp=1", overflow); end
    downloading = 1'b1;
    step();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL drain_ovf_clear got=%b exp=0", overflow); end
    for (int j = 0; j < 4; j++) begin
      logic [EW-1:0] exp = exp_q.pop_front();
      serve_one($urandom_range(0, 2), got, to, st, wa);
      total++;
      if (to || !st || wa !== 1'b0 || got !== exp) begin
        bad++;
        $display("FAIL drain_write%0d got=%h exp=%h timeout=%0b stable=%0b we_after=%b", j, got, exp, to, st, wa);
      end
    end
    begin
      bit extra = 1'b0;
      repeat (6) begin step(); if (prog_we !== 1'b0) extra = 1'b1; end
      total++; if (extra) begin bad++; $display("FAIL drain_no_extra got=1 exp=0"); end
    end
  endtask

  task automatic test_busy();
    logic [EW-1:0] got;
    bit to, st;
    logic wa;
    for (int j = 0; j < 2; j++) begin
      logic [24:0] a = rand_addr();
      logic [7:0]  d = 8'($urandom);
      exp_q.push_back(model(a, d));
      send_byte(a, d);
    end
    downloading = 1'b0;
    for (int j = 0; j < 2; j++) begin
      logic [EW-1:0] exp = exp_q.pop_front();
      serve_one(1, got, to, st, wa);
      total++;
      if (to || got !== exp) begin bad++; $display("FAIL busy_write%0d got=%h exp=%h timeout=%0b", j, got, exp, to); end
      if (j == 0) begin
        total++; if (dwnld_busy !== 1'b1) begin bad++; $display("FAIL busy_mid got=%b exp=1", dwnld_busy); end
      end
    end
    total++; if (dwnld_busy !== 1'b1) begin bad++; $display("FAIL busy_gap got=%b exp=1", dwnld_busy); end
    step();
    total++; if (dwnld_busy !== 1'b1) begin bad++; $display("FAIL busy_after_gap got=%b exp=1", dwnld_busy); end
    step();
    total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b exp=0", dwnld_busy); end
  endtask

  task automatic test_full_pop();
    logic [EW-1:0] got, exp;
    bit to, st;
    logic wa;
    int n = 0;
    logic [24:0] a5 = rand_addr();
    logic [7:0]  d5 = 8'($urandom);
    downloading = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [24:0] a = rand_addr();
      logic [7:0]  d = 8'($urandom);
      exp_q.push_back(model(a, d));
      send_byte(a, d);
    end
    step();
    while (prog_we !== 1'b1 && n < 20) begin step(); n++; end
    got = observed();
    exp = exp_q.pop_front();
    total++; if (prog_we !== 1'b1 || got !== exp)
      begin bad++; $display("FAIL fullpop_head we=%b got=%h exp=%h", prog_we, got, exp); end
    // Fifth byte reaches the FIFO in the very cycle the head is acknowledged.
    exp_q.push_back(model(a5, d5));
    send_byte(a5, d5);
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp = exp_q.pop_front();
      serve_one($urandom_range(0, 2), got, to, st, wa);
      total++;
      if (to || !st || wa !== 1'b0 || got !== exp) begin
        bad++;
        $display("FAIL fullpop_write%0d got=%h exp=%h timeout=%0b stable=%0b we_after=%b", j, got, exp, to, st, wa);
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    bit late = 1'b0;
    downloading = 1'b0;
    repeat (3) step();
    send_byte(rand_addr(), 8'($urandom));
    while (prog_we !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (prog_we !== 1'b1) begin bad++; $display("FAIL rstmid_pre_we got=%b exp=1", prog_we); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (prog_we !== 1'b0)    begin bad++; $display("FAIL rstmid_we got=%b exp=0", prog_we); end
    total++; if (prog_mask !== 2'b11) begin bad++; $display("FAIL rstmid_mask got=%b exp=11", prog_mask); end
    total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", dwnld_busy); end
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    repeat (6) begin step(); if (prog_we !== 1'b0 || dwnld_busy !== 1'b0) late = 1'b1; end
    total++; if (late) begin bad++; $display("FAIL rstmid_late_rdy got=activity exp=idle"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_banks();
    test_random();
    test_overflow();
    test_drain();
    test_busy();
    test_full_pop();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
